// File: rtl/pio_pkg.sv
// Shared definitions for the PIO loader: command action codes, controller
// states and the internal command-pipeline tag.
package pio_pkg;

   localparam logic [3:0] ACT_NOP        = 4'd0;
   localparam logic [3:0] ACT_LOAD_INSTR = 4'd1;
   localparam logic [3:0] ACT_EXEC       = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CONF = 3'd2,
      ST_RUN  = 3'd3,
      ST_EXEC = 3'd4
   } pio_state_e;

   // Kind of command whose ROM read was issued last cycle.
   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_LOAD = 2'd1,
      CMD_CONF = 2'd2
   } cmd_kind_e;

   function automatic logic [31:0] widen_instr(input logic [15:0] instr);
      return {16'h0000, instr};
   endfunction

endpackage

// File: rtl/pio_mask_scan.sv
// Holds a state-machine mask and presents its lowest set bit; advance clears
// that bit so the next one surfaces.
module pio_mask_scan #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             load,
   input  logic [WIDTH-1:0] mask_in,
   input  logic             advance,
   output logic [1:0]       bit_idx,
   output logic             valid,
   output logic             last
);

   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] low_bit;
   logic [WIDTH-1:0] rest;

   always_comb begin
      // Two's-complement trick isolates the lowest set bit.
      low_bit = mask_q & (~mask_q + WIDTH'(1));
      rest    = mask_q & ~low_bit;
      valid   = |mask_q;
      last    = valid && (rest == '0);
      bit_idx = '0;
      for (int unsigned i = WIDTH; i > 0; i--) begin
         if (mask_q[i-1]) bit_idx = 2'(i - 1);
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)     mask_q <= '0;
      else if (load)    mask_q <= mask_in;
      else if (advance) mask_q <= rest;
   end

endmodule

// File: rtl/pio_loader.sv
// Boots a PIO block: streams the program ROM, then per-state-machine config
// ROM entries, then injects instructions on request while running.
module pio_loader
   import pio_pkg::*;
#(
   parameter int unsigned PROG_LEN = 32,
   parameter int unsigned CONF_LEN = 3,
   parameter int unsigned NUM_SM   = 4
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              start,
   output logic [4:0]        prog_addr,
   input  logic [15:0]       prog_data,
   output logic [4:0]        conf_addr,
   input  logic [35:0]       conf_data,
   input  logic              exec_req,
   input  logic [15:0]       exec_instr,
   input  logic [NUM_SM-1:0] exec_mask,
   output logic              exec_ack,
   output logic [3:0]        action,
   output logic [31:0]       din,
   output logic [4:0]        index,
   output logic [1:0]        mindex,
   output logic              busy,
   output logic              ready
);

   localparam int unsigned CONF_TOTAL = NUM_SM * CONF_LEN;
   localparam logic [7:0]  PROG_END   = 8'(PROG_LEN);
   localparam logic [7:0]  CONF_END   = 8'(CONF_TOTAL);
   localparam logic [4:0]  CONF_LAST  = 5'(CONF_LEN - 1);

   pio_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [4:0] c_q, c_d;
   logic [1:0] m_q, m_d;
   cmd_kind_e  kind_q, kind_d;
   logic [4:0] cidx_q, cidx_d;
   logic [1:0] cm_q, cm_d;
   logic [15:0] instr_q, instr_d;
   logic       phase_q, phase_d;
   logic       scan_load, scan_adv;
   logic [1:0] scan_idx;
   logic       scan_valid, scan_last;

   pio_mask_scan #(.WIDTH(NUM_SM)) u_scan (
      .clk     (clk),
      .n_reset (n_reset),
      .load    (scan_load),
      .mask_in (exec_mask),
      .advance (scan_adv),
      .bit_idx (scan_idx),
      .valid   (scan_valid),
      .last    (scan_last)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         c_q     <= '0;
         m_q     <= '0;
         kind_q  <= CMD_NONE;
         cidx_q  <= '0;
         cm_q    <= '0;
         instr_q <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         m_q     <= m_d;
         kind_q  <= kind_d;
         cidx_q  <= cidx_d;
         cm_q    <= cm_d;
         instr_q <= instr_d;
         phase_q <= phase_d;
      end
   end

   // cnt runs one past the last ROM read in LOAD and two past it in CONF, so
   // the trailing command (and the CONF NOP) get their own cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      c_d       = c_q;
      m_d       = m_q;
      kind_d    = CMD_NONE;
      cidx_d    = '0;
      cm_d      = '0;
      instr_d   = instr_q;
      phase_d   = phase_q;
      scan_load = 1'b0;
      scan_adv  = 1'b0;
      exec_ack  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_LOAD;
            cnt_d   = '0;
         end
         ST_LOAD: begin
            if (cnt_q < PROG_END) begin
               kind_d = CMD_LOAD;
               cidx_d = cnt_q[4:0];
               cnt_d  = cnt_q + 8'd1;
            end else begin
               state_d = ST_CONF;
               cnt_d   = '0;
               c_d     = '0;
               m_d     = '0;
            end
         end
         ST_CONF: begin
            if (cnt_q < CONF_END) begin
               kind_d = CMD_CONF;
               cm_d   = m_q;
               cnt_d  = cnt_q + 8'd1;
               if (c_q == CONF_LAST) begin
                  c_d = '0;
                  m_d = m_q + 2'd1;
               end else begin
                  c_d = c_q + 5'd1;
               end
            end else if (cnt_q == CONF_END) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end else if (exec_req) begin
               exec_ack = 1'b1;
               if (|exec_mask) begin
                  instr_d   = exec_instr;
                  scan_load = 1'b1;
                  phase_d   = 1'b0;
                  state_d   = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d  = 1'b0;
               scan_adv = 1'b1;
               if (scan_last || !scan_valid) state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      action = ACT_NOP;
      din    = '0;
      index  = '0;
      mindex = '0;
      case (kind_q)
         CMD_LOAD: begin
            action = ACT_LOAD_INSTR;
            din    = widen_instr(prog_data);
            index  = cidx_q;
         end
         CMD_CONF: begin
            action = conf_data[35:32];
            din    = conf_data[31:0];
            mindex = cm_q;
         end
         default: ;
      endcase
      if (state_q == ST_EXEC && !phase_q) begin
         action = ACT_EXEC;
         din    = widen_instr(instr_q);
         mindex = scan_idx;
      end
   end

   assign prog_addr = (state_q == ST_LOAD && cnt_q < PROG_END) ? cnt_q[4:0] : '0;
   assign conf_addr = (state_q == ST_CONF && cnt_q < CONF_END) ? c_q : '0;
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_CONF);
   assign ready     = (state_q == ST_RUN)  || (state_q == ST_EXEC);

endmodule
